// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Channel counters must be no wider than MAX_WIDTH because the clamp helper works at that width.
package clk_div_pkg;

    localparam int unsigned MIN_PERIOD = 2;
    localparam int unsigned DEF_WIDTH  = 24;
    localparam int unsigned MAX_WIDTH  = 32;

    // Periods of 0 or 1 cannot produce a wrap, so they run as MIN_PERIOD.
    function automatic logic [MAX_WIDTH-1:0] clamp_period(input logic [MAX_WIDTH-1:0] period);
        return (period < MAX_WIDTH'(MIN_PERIOD)) ? MAX_WIDTH'(MIN_PERIOD) : period;
    endfunction

    function automatic int unsigned ch_idx_width(input int unsigned channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active and shadow period/high registers,
// pending flag and registered clk_out/tick outputs.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned DEF_PERIOD = 3_000_000,
    parameter int unsigned DEF_HIGH   = 1_500_000
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_period,
    input  logic [WIDTH-1:0] wr_high,
    output logic             pending,
    output logic             clk_out,
    output logic             tick
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] act_period_q, act_period_d;
    logic [WIDTH-1:0] act_high_q, act_high_d;
    logic [WIDTH-1:0] shd_period_q, shd_period_d;
    logic [WIDTH-1:0] shd_high_q, shd_high_d;
    logic             pending_q, pending_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;

    logic [WIDTH-1:0] period_eff;
    logic             last;
    logic             apply;

    assign period_eff = WIDTH'(clamp_period(MAX_WIDTH'(act_period_q)));
    assign last       = (cnt_q == (period_eff - WIDTH'(1)));
    // Active values may only change at a period boundary, while idle, or on a restart.
    assign apply      = last || !en || sync;

    always_comb begin
        cnt_d        = cnt_q;
        act_period_d = act_period_q;
        act_high_d   = act_high_q;
        shd_period_d = shd_period_q;
        shd_high_d   = shd_high_q;
        pending_d    = pending_q;
        clk_out_d    = en && (cnt_q < act_high_q);
        tick_d       = en && last;

        if (!en || sync || last) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + WIDTH'(1);
        end

        if (wr) begin
            shd_period_d = wr_period;
            shd_high_d   = wr_high;
            if (apply) begin
                act_period_d = wr_period;
                act_high_d   = wr_high;
                pending_d    = 1'b0;
            end else begin
                pending_d    = 1'b1;
            end
        end else if (apply) begin
            // Shadow equals active whenever nothing is pending, so copying is always safe.
            act_period_d = shd_period_q;
            act_high_d   = shd_high_q;
            pending_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            cnt_q        <= '0;
            act_period_q <= WIDTH'(DEF_PERIOD);
            act_high_q   <= WIDTH'(DEF_HIGH);
            shd_period_q <= WIDTH'(DEF_PERIOD);
            shd_high_q   <= WIDTH'(DEF_HIGH);
            pending_q    <= 1'b0;
            clk_out_q    <= 1'b0;
            tick_q       <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            act_period_q <= act_period_d;
            act_high_q   <= act_high_d;
            shd_period_q <= shd_period_d;
            shd_high_q   <= shd_high_d;
            pending_q    <= pending_d;
            clk_out_q    <= clk_out_d;
            tick_q       <= tick_d;
        end
    end

    assign pending = pending_q;
    assign clk_out = clk_out_q;
    assign tick    = tick_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider / strobe generator: decodes configuration
// writes to per-channel strobes and fans enable and sync out to each channel.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned DEF_PERIOD = 3_000_000,
    parameter int unsigned DEF_HIGH   = 1_500_000
) (
    input  logic                                 clk_in,
    input  logic                                 rst,
    input  logic [CHANNELS-1:0]                  en,
    input  logic                                 sync,
    input  logic                                 cfg_we,
    input  logic [ch_idx_width(CHANNELS)-1:0]    cfg_ch,
    input  logic [WIDTH-1:0]                     cfg_period,
    input  logic [WIDTH-1:0]                     cfg_high,
    output logic [CHANNELS-1:0]                  cfg_pending,
    output logic [CHANNELS-1:0]                  clk_out,
    output logic [CHANNELS-1:0]                  tick
);

    localparam int unsigned CH_W = ch_idx_width(CHANNELS);

    logic [CHANNELS-1:0] wr_sel;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            // Indices at or above CHANNELS match no channel and are dropped.
            assign wr_sel[gi] = cfg_we && (cfg_ch == CH_W'(gi));

            clk_div_chan #(
                .WIDTH      (WIDTH),
                .DEF_PERIOD (DEF_PERIOD),
                .DEF_HIGH   (DEF_HIGH)
            ) u_chan (
                .clk_in     (clk_in),
                .rst        (rst),
                .en         (en[gi]),
                .sync       (sync),
                .wr         (wr_sel[gi]),
                .wr_period  (cfg_period),
                .wr_high    (cfg_high),
                .pending    (cfg_pending[gi]),
                .clk_out    (clk_out[gi]),
                .tick       (tick[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi with short default period (10/5) and three channels.
module tb_clk_div_multi;

    localparam int unsigned WIDTH = 24;
    localparam int unsigned NCH   = 3;

    logic             clk_in;
    logic             rst;
    logic [NCH-1:0]   en;
    logic             sync;
    logic             cfg_we;
    logic [1:0]       cfg_ch;
    logic [WIDTH-1:0] cfg_period;
    logic [WIDTH-1:0] cfg_high;
    logic [NCH-1:0]   cfg_pending;
    logic [NCH-1:0]   clk_out;
    logic [NCH-1:0]   tick;

    int n_checks = 0;
    int n_fail   = 0;

    clk_div_multi #(
        .WIDTH      (WIDTH),
        .CHANNELS   (NCH),
        .DEF_PERIOD (10),
        .DEF_HIGH   (5)
    ) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .en          (en),
        .sync        (sync),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_period  (cfg_period),
        .cfg_high    (cfg_high),
        .cfg_pending (cfg_pending),
        .clk_out     (clk_out),
        .tick        (tick)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Expected outputs of channel ch for the cycle whose counter value was ph.
    task automatic check_chan(input string tag, input int ch, input int p, input int h,
                              input int ph, input bit pend);
        check_val({tag, "_clk"},  32'(clk_out[ch]),     32'(ph < h));
        check_val({tag, "_tick"}, 32'(tick[ch]),        32'(ph == p - 1));
        check_val({tag, "_pend"}, 32'(cfg_pending[ch]), 32'(pend));
    endtask

    task automatic expect_wave(input string tag, input int ch, input int n, input int p,
                               input int h, input int ph0, input bit pend);
        for (int k = 0; k < n; k++) begin
            step();
            check_chan(tag, ch, p, h, (ph0 + k) % p, pend);
        end
    endtask

    task automatic do_write(input int ch, input int p, input int h);
        cfg_we     = 1'b1;
        cfg_ch     = 2'(ch);
        cfg_period = WIDTH'(p);
        cfg_high   = WIDTH'(h);
        $display("cfg write ch=%0d period=%0d high=%0d t=%0t", ch, p, h, $time);
    endtask

    // Disable the channel, write directly into the active registers, re-enable.
    task automatic reload(input int ch, input int p, input int h);
        en[ch] = 1'b0;
        do_write(ch, p, h);
        step();
        cfg_we = 1'b0;
        check_val("reload_clk",  32'(clk_out[ch]),     32'd0);
        check_val("reload_tick", 32'(tick[ch]),        32'd0);
        check_val("reload_pend", 32'(cfg_pending[ch]), 32'd0);
        en[ch] = 1'b1;
    endtask

    initial begin
        rst = 1'b0; en = '0; sync = 1'b0; cfg_we = 1'b0;
        cfg_ch = '0; cfg_period = '0; cfg_high = '0;
        repeat (3) step();
        check_val("rst_clk",  32'(clk_out),     32'd0);
        check_val("rst_tick", 32'(tick),        32'd0);
        check_val("rst_pend", 32'(cfg_pending), 32'd0);

        // 1: defaults 10/5
        rst = 1'b1;
        en  = 3'b001;
        expect_wave("t1", 0, 20, 10, 5, 0, 1'b0);

        // 2: write 6/2 at cnt=3, old period completes first
        expect_wave("t2_pre", 0, 3, 10, 5, 0, 1'b0);
        do_write(0, 6, 2);
        expect_wave("t2_wr", 0, 1, 10, 5, 3, 1'b1);
        cfg_we = 1'b0;
        expect_wave("t2_old", 0, 5, 10, 5, 4, 1'b1);
        expect_wave("t2_wrap", 0, 1, 10, 5, 9, 1'b0);
        expect_wave("t2_new", 0, 12, 6, 2, 0, 1'b0);

        // 3: edge values
        reload(0, 8, 0);
        expect_wave("t3_h0", 0, 16, 8, 0, 0, 1'b0);
        reload(0, 8, 8);
        expect_wave("t3_hp", 0, 16, 8, 8, 0, 1'b0);
        reload(0, 0, 1);
        expect_wave("t3_p0", 0, 6, 2, 1, 0, 1'b0);
        reload(0, 1, 1);
        expect_wave("t3_p1", 0, 6, 2, 1, 0, 1'b0);

        // 4: sync two channels at different phases
        reload(0, 10, 5);
        expect_wave("t4_a", 0, 3, 10, 5, 0, 1'b0);
        en[1] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            check_chan("t4_b0", 0, 10, 5, 3 + k, 1'b0);
            check_chan("t4_b1", 1, 10, 5, k, 1'b0);
        end
        sync = 1'b1;
        step();
        sync = 1'b0;
        check_chan("t4_s0", 0, 10, 5, 5, 1'b0);
        check_chan("t4_s1", 1, 10, 5, 2, 1'b0);
        for (int k = 0; k < 12; k++) begin
            step();
            check_chan("t4_c0", 0, 10, 5, k % 10, 1'b0);
            check_chan("t4_c1", 1, 10, 5, k % 10, 1'b0);
        end

        // 5: disable ch2 mid-period, reprogram, re-enable
        en[2] = 1'b1;
        expect_wave("t5_run", 2, 3, 10, 5, 0, 1'b0);
        en[2] = 1'b0;
        step();
        check_val("t5_off_clk",  32'(clk_out[2]), 32'd0);
        check_val("t5_off_tick", 32'(tick[2]),    32'd0);
        do_write(2, 4, 1);
        step();
        cfg_we = 1'b0;
        check_val("t5_wr_clk",  32'(clk_out[2]),     32'd0);
        check_val("t5_wr_pend", 32'(cfg_pending[2]), 32'd0);
        step();
        check_val("t5_idle_clk", 32'(clk_out[2]), 32'd0);
        en[2] = 1'b1;
        expect_wave("t5_new", 2, 8, 4, 1, 0, 1'b0);

        // last write wins; out-of-range channel ignored
        do_write(2, 7, 2);
        expect_wave("t6_w1", 2, 1, 4, 1, 0, 1'b1);
        do_write(2, 5, 3);
        expect_wave("t6_w2", 2, 1, 4, 1, 1, 1'b1);
        do_write(3, 9, 9);
        expect_wave("t6_w3", 2, 1, 4, 1, 2, 1'b1);
        check_val("t6_pend_vec", 32'(cfg_pending), 32'b100);
        cfg_we = 1'b0;
        expect_wave("t6_apply", 2, 1, 4, 1, 3, 1'b0);
        expect_wave("t6_last", 2, 10, 5, 3, 0, 1'b0);

        // 6: async reset mid-period with a pending write
        do_write(2, 9, 1);
        expect_wave("t6_pre", 2, 1, 5, 3, 0, 1'b1);
        cfg_we = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_val("t6_rst_clk",  32'(clk_out),     32'd0);
        check_val("t6_rst_tick", 32'(tick),        32'd0);
        check_val("t6_rst_pend", 32'(cfg_pending), 32'd0);
        step();
        rst = 1'b1;
        expect_wave("t6_def", 2, 12, 10, 5, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
